// File: rtl/bp_addr_pkg.sv
// Shared types for the LSTM backprop address generators: sequencer states,
// weight-sweep mode codes and the default address type.
package bp_addr_pkg;
  localparam int BP_ADDR_W = 12;
  typedef logic [BP_ADDR_W-1:0] addr_t;

  localparam logic MODE_W = 1'b0;
  localparam logic MODE_U = 1'b1;

  typedef enum logic [1:0] {IDLE, SWEEP, GAP, FIN} state_t;
endpackage

// File: rtl/bp_sweep_counter.sv
// Shared up-counter for the sweep index and the inter-sweep gap, with terminal
// count flags for both lengths; clear has priority over enable.
module bp_sweep_counter #(
  parameter int W     = 12,
  parameter int LEN_A = 53,
  parameter int LEN_B = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_tc_a,
  output logic         o_tc_b
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt  = r_cnt;
  assign o_tc_a = (r_cnt == W'(LEN_A - 1));
  // A zero-length gap is never entered, so its flag is simply held high.
  assign o_tc_b = (LEN_B == 0) ? 1'b1 : (r_cnt == W'(LEN_B - 1));
endmodule

// File: rtl/addr_gen_bp_sweep.sv
// Backprop read-address generator: walks timesteps newest-first, one column
// sweep of NUM_CELL delta-gate/weight address pairs per output element.
module addr_gen_bp_sweep
  import bp_addr_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMESTEP   = 7,
  parameter int NUM_CELL   = 53,
  parameter int NUM_INPUT  = 53,
  parameter int DELAY      = 2,
  parameter int D_BASE     = 0,
  parameter int W_BASE     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] o_addr_d,
  output logic [ADDR_WIDTH-1:0] o_addr_w,
  output logic                  o_valid,
  output logic                  o_first,
  output logic                  o_last,
  output logic [ADDR_WIDTH-1:0] o_t_idx,
  output logic [ADDR_WIDTH-1:0] o_col_idx,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int AW = ADDR_WIDTH;
  localparam longint MAXCOL = (NUM_INPUT > NUM_CELL) ? NUM_INPUT : NUM_CELL;
  localparam logic [AW-1:0] C_ONE   = AW'(1);
  localparam logic [AW-1:0] C_NC    = AW'(NUM_CELL);
  localparam logic [AW-1:0] C_NI    = AW'(NUM_INPUT);
  localparam logic [AW-1:0] C_WB    = AW'(W_BASE);
  localparam logic [AW-1:0] C_TINIT = AW'(TIMESTEP - 1);
  localparam logic [AW-1:0] C_DINIT = AW'(D_BASE + (TIMESTEP - 1) * NUM_CELL);

  if (longint'(D_BASE) + longint'(TIMESTEP) * NUM_CELL > (longint'(1) << AW)) begin : g_chk_d
    $error("addr_gen_bp_sweep: delta-gate address range exceeds ADDR_WIDTH");
  end
  if (longint'(W_BASE) + longint'(NUM_CELL) * MAXCOL > (longint'(1) << AW)) begin : g_chk_w
    $error("addr_gen_bp_sweep: weight address range exceeds ADDR_WIDTH");
  end

  state_t        r_state, w_next;
  logic          r_mode;
  logic [AW-1:0] r_t, r_col, r_dt, r_wcol, r_d, r_w;
  logic [AW-1:0] w_ncol, w_cnt;
  logic          w_adv, w_k_tc, w_gap_tc, w_col_end, w_final, w_new_sweep;
  logic          w_cnt_en, w_cnt_clr;
  logic          w_valid, w_first, w_last, w_busy, w_done;
  logic          r_o_valid, r_o_first, r_o_last, r_o_busy, r_o_done;
  logic [AW-1:0] r_o_d, r_o_w, r_o_t, r_o_col;

  assign w_adv     = ~stall;
  assign w_ncol    = (r_mode == MODE_U) ? C_NC : C_NI;
  assign w_col_end = (r_col == w_ncol - C_ONE);
  assign w_final   = (r_t == '0) && w_col_end;

  bp_sweep_counter #(.W(AW), .LEN_A(NUM_CELL), .LEN_B(DELAY)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_cnt_en),
    .i_clr  (w_cnt_clr),
    .o_cnt  (w_cnt),
    .o_tc_a (w_k_tc),
    .o_tc_b (w_gap_tc)
  );

  assign w_cnt_en  = w_adv && (r_state == SWEEP || r_state == GAP);
  assign w_cnt_clr = w_adv && ((r_state == SWEEP && w_k_tc) || (r_state == GAP && w_gap_tc) ||
                               r_state == IDLE || r_state == FIN);
  assign w_new_sweep = w_adv && ((r_state == SWEEP && w_k_tc && !w_final && DELAY == 0) ||
                                 (r_state == GAP && w_gap_tc));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_state <= IDLE;
    else if (w_adv) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start) w_next = SWEEP;
      SWEEP: if (w_k_tc) begin
               if (w_final)         w_next = FIN;
               else if (DELAY == 0) w_next = SWEEP;
               else                 w_next = GAP;
             end
      GAP:   if (w_gap_tc) w_next = SWEEP;
      FIN:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_valid = (r_state == SWEEP);
    w_first = (r_state == SWEEP) && (w_cnt == '0);
    w_last  = (r_state == SWEEP) && w_k_tc;
    w_busy  = (r_state != IDLE);
    w_done  = (r_state == FIN);
  end

  // r_dt tracks the delta-gate row base for t, r_wcol the weight column base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_W;
      r_t    <= C_TINIT;
      r_col  <= '0;
      r_dt   <= C_DINIT;
      r_wcol <= C_WB;
      r_d    <= C_DINIT;
      r_w    <= C_WB;
    end else if (w_adv) begin
      if (r_state == IDLE && start) r_mode <= mode;
      if (r_state == SWEEP && !w_k_tc) begin
        r_d <= r_d + C_ONE;
        r_w <= r_w + w_ncol;
      end
      if (w_new_sweep) begin
        if (w_col_end) begin
          r_col  <= '0;
          r_t    <= r_t - C_ONE;
          r_dt   <= r_dt - C_NC;
          r_d    <= r_dt - C_NC;
          r_wcol <= C_WB;
          r_w    <= C_WB;
        end else begin
          r_col  <= r_col + C_ONE;
          r_d    <= r_dt;
          r_wcol <= r_wcol + C_ONE;
          r_w    <= r_wcol + C_ONE;
        end
      end
      if (r_state == FIN) begin
        r_t    <= C_TINIT;
        r_col  <= '0;
        r_dt   <= C_DINIT;
        r_wcol <= C_WB;
        r_d    <= C_DINIT;
        r_w    <= C_WB;
      end
    end
  end

  // Output stage: one register behind the sequencer, frozen together with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o_valid <= 1'b0;
      r_o_first <= 1'b0;
      r_o_last  <= 1'b0;
      r_o_busy  <= 1'b0;
      r_o_done  <= 1'b0;
      r_o_d     <= C_DINIT;
      r_o_w     <= C_WB;
      r_o_t     <= C_TINIT;
      r_o_col   <= '0;
    end else if (w_adv) begin
      r_o_valid <= w_valid;
      r_o_first <= w_first;
      r_o_last  <= w_last;
      r_o_busy  <= w_busy;
      r_o_done  <= w_done;
      r_o_d     <= r_d;
      r_o_w     <= r_w;
      r_o_t     <= r_t;
      r_o_col   <= r_col;
    end
  end

  assign o_addr_d  = r_o_d;
  assign o_addr_w  = r_o_w;
  assign o_t_idx   = r_o_t;
  assign o_col_idx = r_o_col;
  assign o_busy    = r_o_busy;
  assign o_valid   = r_o_valid & ~stall;
  assign o_first   = r_o_first & ~stall;
  assign o_last    = r_o_last  & ~stall;
  assign o_done    = r_o_done  & ~stall;
endmodule

// File: tb/tb_addr_gen_bp_sweep.sv
// Bench for addr_gen_bp_sweep: three small configurations checked cycle by
// cycle against a slot-list model built from the address equations.
module tb_addr_gen_bp_sweep;
  localparam int NC = 3;
  localparam int NI = 2;
  localparam int T  = 2;

  typedef struct packed {
    logic [11:0] d, w, t, col;
    logic        valid, first, last, busy, done;
  } slot_t;

  logic        clk;
  logic        rst_a   [3];
  logic        start_a [3];
  logic        mode_a  [3];
  logic        stall_a [3];
  logic [11:0] od_a [3], ow_a [3], ot_a [3], oc_a [3];
  logic        ov_a [3], of_a [3], ol_a [3], ob_a [3], odn_a [3];

  int    n_checks = 0;
  int    n_err    = 0;
  int    n_valid;
  int    done_cyc;
  int    cyc;
  int    sel = 0;
  bit    chk_en = 0;
  slot_t exp_s;
  slot_t q[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    addr_gen_bp_sweep #(
      .ADDR_WIDTH(12), .TIMESTEP(T), .NUM_CELL(NC), .NUM_INPUT(NI),
      .DELAY(g == 1 ? 0 : 2), .D_BASE(g == 2 ? 100 : 0), .W_BASE(g == 2 ? 200 : 0)
    ) u_dut (
      .clk(clk), .rst(rst_a[g]), .start(start_a[g]), .mode(mode_a[g]), .stall(stall_a[g]),
      .o_addr_d(od_a[g]), .o_addr_w(ow_a[g]), .o_valid(ov_a[g]), .o_first(of_a[g]),
      .o_last(ol_a[g]), .o_t_idx(ot_a[g]), .o_col_idx(oc_a[g]), .o_busy(ob_a[g]),
      .o_done(odn_a[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dbase(input int s);
    return (s == 2) ? 100 : 0;
  endfunction

  function automatic int wbase(input int s);
    return (s == 2) ? 200 : 0;
  endfunction

  function automatic slot_t parked(input int s);
    slot_t p;
    p     = '0;
    p.d   = 12'(dbase(s) + (T - 1) * NC);
    p.w   = 12'(wbase(s));
    p.t   = 12'(T - 1);
    return p;
  endfunction

  // Expected unstalled output sequence of one run, starting the cycle after start.
  task automatic build(input int s, input int md);
    int    ncol, dl;
    slot_t sl, hold;
    bit    first_sweep;
    ncol = md ? NC : NI;
    dl = (s == 1) ? 0 : 2;
    first_sweep = 1;
    hold = '0;
    q.delete();
    for (int t = T - 1; t >= 0; t--) begin
      for (int col = 0; col < ncol; col++) begin
        if (!first_sweep) begin
          for (int g = 0; g < dl; g++) q.push_back(hold);
        end
        first_sweep = 0;
        for (int k = 0; k < NC; k++) begin
          sl.d = 12'(dbase(s) + t * NC + k);
          sl.w = 12'(wbase(s) + k * ncol + col);
          sl.t = 12'(t);
          sl.col = 12'(col);
          sl.valid = 1'b1;
          sl.first = (k == 0);
          sl.last = (k == NC - 1);
          sl.busy = 1'b1;
          sl.done = 1'b0;
          q.push_back(sl);
          hold = sl;
          hold.valid = 1'b0;
          hold.first = 1'b0;
          hold.last = 1'b0;
        end
      end
    end
    hold.done = 1'b1;
    q.push_back(hold);
  endtask

  task automatic chk(input string nm, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  always @(posedge clk) begin
    slot_t act;
    #3;
    if (chk_en) begin
      act = {od_a[sel], ow_a[sel], ot_a[sel], oc_a[sel], ov_a[sel], of_a[sel],
             ol_a[sel], ob_a[sel], odn_a[sel]};
      n_checks++;
      if (act !== exp_s) begin
        n_err++;
        $display("FAIL dut%0d cycle %0d: got d=%0d w=%0d t=%0d c=%0d v%b f%b l%b b%b dn%b expected d=%0d w=%0d t=%0d c=%0d v%b f%b l%b b%b dn%b",
                 sel, cyc, act.d, act.w, act.t, act.col, act.valid, act.first, act.last, act.busy, act.done,
                 exp_s.d, exp_s.w, exp_s.t, exp_s.col, exp_s.valid, exp_s.first, exp_s.last, exp_s.busy, exp_s.done);
      end
      if (act.valid) n_valid++;
      if (act.done) done_cyc = cyc;
    end
  end

  // One run: start sampled at edge 0; cycle c is observed after edge c.
  task automatic run(input int s, input int md, input int stall_c, input int stall_n,
                     input int rst_c, input int restart_c);
    int    idx;
    bit    active, stl;
    slot_t e;
    build(s, md);
    @(posedge clk); #1;
    sel = s;
    cyc = -1;
    n_valid = 0;
    done_cyc = -1;
    start_a[s] = 1'b1;
    mode_a[s] = md[0];
    exp_s = parked(s);
    chk_en = 1;
    idx = 0;
    active = 0;
    for (int c = 0; c < q.size() + stall_n + 4; c++) begin
      @(posedge clk); #1;
      cyc = c;
      start_a[s] = (c == restart_c);
      mode_a[s] = ~md[0];
      stl = (c >= stall_c) && (c < stall_c + stall_n);
      stall_a[s] = stl;
      rst_a[s] = (c == rst_c);
      if (c == rst_c) active = 0;
      else if (c == 1 && (rst_c < 0 || rst_c > 1)) active = 1;
      if (active && idx < q.size()) begin
        e = q[idx];
        if (stl) begin
          e.valid = 1'b0;
          e.first = 1'b0;
          e.last = 1'b0;
          e.done = 1'b0;
        end else begin
          idx++;
        end
        exp_s = e;
      end else begin
        exp_s = parked(s);
      end
    end
    @(posedge clk); #1;
    chk_en = 0;
    start_a[s] = 1'b0;
    stall_a[s] = 1'b0;
    rst_a[s] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b1;
      start_a[i] = 1'b0;
      mode_a[i] = 1'b0;
      stall_a[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
    #2;
    chk("reset_d", od_a[0], 3);
    chk("reset_w", ow_a[0], 0);
    chk("reset_t", ot_a[0], 1);
    chk("reset_busy", ob_a[0], 0);
    chk("reset_d_base", od_a[2], 103);
    chk("reset_w_base", ow_a[2], 200);

    build(0, 0);
    chk("model1_len", q.size(), 19);
    chk("model1_d1", q[1].d, 4);
    chk("model1_w1", q[1].w, 2);
    chk("model1_d15", q[15].d, 0);
    chk("model1_w15", q[15].w, 1);
    chk("model1_done", q[18].done, 1);
    build(0, 1);
    chk("model2_len", q.size(), 29);
    chk("model2_w6", q[6].w, 4);
    build(2, 0);
    chk("model6_d0", q[0].d, 103);

    run(0, 0, -1, 0, -1, -1);
    chk("s1_valid_cnt", n_valid, 12);
    chk("s1_done_cyc", done_cyc, 19);
    run(0, 1, -1, 0, -1, -1);
    chk("s2_valid_cnt", n_valid, 18);
    chk("s2_done_cyc", done_cyc, 29);
    run(1, 0, -1, 0, -1, -1);
    chk("s3_valid_cnt", n_valid, 12);
    chk("s3_done_cyc", done_cyc, 13);
    run(0, 0, 2, 3, -1, -1);
    chk("s4_valid_cnt", n_valid, 12);
    chk("s4_done_cyc", done_cyc, 22);
    run(0, 0, -1, 0, 7, -1);
    chk("s5_valid_cnt", n_valid, 4);
    chk("s5_no_done", done_cyc, -1);
    run(0, 0, -1, 0, -1, -1);
    chk("s5_rerun_done", done_cyc, 19);
    run(0, 0, -1, 0, -1, 5);
    chk("s6_done_cyc", done_cyc, 19);
    run(2, 0, -1, 0, -1, 5);
    chk("s6_base_valid", n_valid, 12);
    chk("s6_base_done", done_cyc, 19);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/addr_gen_bp_sweep.md
Name: addr_gen_bp_sweep

Overview:
- Parametrised read-address generator for LSTM backpropagation.
- Produces paired δgates addresses and transposed W/U weight addresses for the δx/δh matrix-vector products.
- Walks timesteps newest-to-oldest. Per timestep it makes one column sweep per output element, with a programmable idle gap between sweeps.
- Adds to the earlier free-running generator: start/busy/done handshake, stall, address-valid and sweep-boundary markers, base offsets, and a W/U mode select.

Parameters:
- ADDR_WIDTH, 12: width of both address outputs and of the internal counters.
- TIMESTEP, 7: number of timesteps walked.
- NUM_CELL, 53: δgates elements per timestep; also the sweep length.
- NUM_INPUT, 53: weight columns in W mode.
- DELAY, 2: idle cycles between consecutive sweeps. 0 is legal.
- D_BASE, 0: base address of the δgates buffer.
- W_BASE, 0: base address of the weight buffer.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a run when idle
- mode  in  1  0 = W sweep (NCOL = NUM_INPUT, δx); 1 = U sweep (NCOL = NUM_CELL, δh); sampled at start
- stall  in  1  freezes all sequencing while high
- o_addr_d  out  ADDR_WIDTH  δgates read address
- o_addr_w  out  ADDR_WIDTH  weight read address
- o_valid  out  1  address pair is a real read this cycle
- o_first  out  1  first address of a sweep; MAC clears its accumulator
- o_last  out  1  last address of a sweep; MAC emits its result
- o_t_idx  out  ADDR_WIDTH  current timestep
- o_col_idx  out  ADDR_WIDTH  current column
- o_busy  out  1  run in progress
- o_done  out  1  one-cycle pulse at end of run

Behaviour:
- States:
  - IDLE: outputs parked.
  - SWEEP: k = 0..NUM_CELL-1, one per cycle.
  - GAP: DELAY cycles.
  - FIN: one cycle.
- Address equations, modulo 2^ADDR_WIDTH:
  - o_addr_d = D_BASE + t*NUM_CELL + k
  - o_addr_w = W_BASE + k*NCOL + col
  - Both are computed incrementally: d += 1, w += NCOL. No multiplier.
- Order:
  - Outer loop: t from TIMESTEP-1 down to 0.
  - Middle loop: col from 0 up to NCOL-1.
  - Inner loop: k.
- Latency: start sampled high in IDLE at edge N makes the first valid address visible after edge N+1.
- IDLE -> SWEEP on start. mode is latched at that edge. start while busy is ignored.
- SWEEP -> GAP after k = NUM_CELL-1, unless this is the final sweep (t = 0, col = NCOL-1), which goes to FIN.
  - With DELAY = 0, SWEEP goes straight to the next sweep, back-to-back.
- GAP -> SWEEP after DELAY cycles.
  - On entry to the next SWEEP, col increments.
  - If col wraps from NCOL-1 to 0, t decrements.
- FIN: o_done = 1 for one cycle, then IDLE.
- o_valid is high exactly in SWEEP cycles.
- o_first = o_valid & (k == 0).
- o_last = o_valid & (k == NUM_CELL-1).
- With NUM_CELL = 1, o_first and o_last are both high on the same cycle.
- o_busy is high in SWEEP, GAP and FIN.
- Addresses hold their last value during GAP.
- In IDLE, addresses park at reset values.
- Stall:
  - While stall = 1, state, counters and all registered outputs hold.
  - o_valid, o_first, o_last and o_done are gated low combinationally while stall is high.
  - The held address is presented again, valid, in the first cycle after stall falls. No address is skipped or duplicated-valid.
  - stall in IDLE also blocks start.
- Reset values:
  - o_addr_d = D_BASE + (TIMESTEP-1)*NUM_CELL.
  - o_addr_w = W_BASE.
  - o_t_idx = TIMESTEP-1.
  - o_col_idx = 0.
  - All flags 0.
  - State IDLE.
- Reset mid-run: immediate return to reset values. No done pulse is emitted.
- Elaboration-time checks:
  - D_BASE + TIMESTEP*NUM_CELL must fit in ADDR_WIDTH.
  - W_BASE + NUM_CELL*max(NUM_INPUT, NUM_CELL) must fit in ADDR_WIDTH.
  - Violation is an error, not a silent wrap.

Decomposition:
- Shared package bp_addr_pkg holds:
  - the state enum (IDLE/SWEEP/GAP/FIN);
  - MODE_W = 0, MODE_U = 1;
  - an addr_t typedef sized by ADDR_WIDTH.
- One natural sub-module: bp_sweep_counter.
  - Contains the k/gap counter with terminal-count flags.
  - Reusable by the forward-pass generators.
- Timestep/column sequencing and address accumulation stay in the top.

Test Plan:
All scenarios use NUM_CELL=3, NUM_INPUT=2, TIMESTEP=2, DELAY=2, bases 0.
1. Mode 0, start at cycle 0:
   - Valid d/w pairs: 3/0, 4/2, 5/4; 3/1, 4/3, 5/5; 0/0, 1/2, 2/4; 0/1, 1/3, 2/5.
   - Valid cycles 1-3, 6-8, 11-13, 16-18.
   - o_done at cycle 19, busy cycles 1-19.
2. Mode 1:
   - w per sweep is 0,3,6 / 1,4,7 / 2,5,8, repeated for t=1 then t=0.
   - 18 valid cycles; last valid at cycle 28; done at cycle 29.
3. DELAY=0, mode 0:
   - 12 consecutive valid cycles, 1-12; done at cycle 13.
   - o_first/o_last on every third cycle.
4. Stall high for 3 cycles on the second address (4/2):
   - Addresses hold and valid is low during the stall.
   - 4/2 is presented valid once after release; total run extends by exactly 3 cycles.
5. rst asserted at cycle 7, mid-sweep:
   - Outputs return to d=3, w=0, busy=0 with no done pulse.
   - A subsequent start reproduces scenario 1 exactly.
6. start pulsed again at cycle 5 during a run:
   - Ignored; the sequence is identical to scenario 1.
   - With D_BASE=100 and W_BASE=200, every address is offset accordingly.
